// File: rtl/sram_responder_if.sv
// Strobe and address pins of the async 16-bit SRAM bus.
// The bidirectional DQ bus stays a plain inout on the responder.
interface sram_responder_if;
    logic [19:0] sram_addr;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport master (
        output sram_addr, sram_ce_n, sram_oe_n,
        output sram_we_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        input sram_addr, sram_ce_n, sram_oe_n,
        input sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for an async 16-bit SRAM chip with access counters.
// Define SRAM_RESP_INIT_EN to load a descending pattern into memory on reset.
module sram_responder #(
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_responder_if.slave bus,
    inout  wire  [15:0] sram_dq,
    output logic [7:0]  wr_cnt,
    output logic [7:0]  rd_cnt,
    output logic [7:0]  err_cnt,
    output logic [1:0]  state
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } st_t;

    st_t st;

    logic              w;
    logic              r;
    logic              oor;
    logic [ADDR_W-1:0] a;

    assign w   = !bus.sram_ce_n && !bus.sram_we_n;
    assign r   = !bus.sram_ce_n && !bus.sram_oe_n && bus.sram_we_n;
    assign oor = |bus.sram_addr[19:ADDR_W];
    assign a   = bus.sram_addr[ADDR_W-1:0];

    logic [ADDR_W-1:0] pend_addr;
    logic              pend_oor;
    logic [15:0]       pend_data;
    logic [1:0]        pend_be;
    logic [15:0]       pend_mask;

    assign pend_mask = {{8{pend_be[1]}}, {8{pend_be[0]}}};

    logic        prev_r;
    logic [19:0] prev_addr;

    logic commit;
    logic commit_wr;
    logic commit_err;
    logic rd_start;
    logic rd_err;

    assign commit     = (st == WRITE) && !w;
    assign commit_wr  = commit && |pend_be && !pend_oor;
    assign commit_err = commit && |pend_be && pend_oor;
    assign rd_start   = r && (!prev_r || bus.sram_addr != prev_addr);
    assign rd_err     = rd_start && oor;

    // A read start and an out-of-range commit can land on the same edge.
    logic [8:0] err_sum;
    logic [7:0] err_next;

    assign err_sum  = {1'b0, err_cnt} + 9'(commit_err) + 9'(rd_err);
    assign err_next = err_sum[8] ? 8'hff : err_sum[7:0];

    logic [15:0] mem [DEPTH];
    logic [15:0] mem_word;
    logic [15:0] rd_word;

    assign mem_word = mem[a];

    always_comb begin
        rd_word = mem_word;
        if (st == WRITE && !pend_oor && pend_addr == a)
            rd_word = (mem_word & ~pend_mask) | (pend_data & pend_mask);
        if (oor)
            rd_word = 16'h0000;
    end

`ifdef SRAM_RESP_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= {8'h00, 8'(DEPTH - 1 - i)};
        end else if (commit_wr) begin
            if (pend_be[0]) mem[pend_addr][7:0]  <= pend_data[7:0];
            if (pend_be[1]) mem[pend_addr][15:8] <= pend_data[15:8];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            if (pend_be[0]) mem[pend_addr][7:0]  <= pend_data[7:0];
            if (pend_be[1]) mem[pend_addr][15:8] <= pend_data[15:8];
        end
    end
`endif

    logic [15:0] dout;

    generate
        if (RD_LAT == 0) begin : g_comb
            assign dout = rd_word;
        end else begin : g_pipe
            logic [15:0] pipe [RD_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LAT; i++)
                        pipe[i] <= 16'h0000;
                end else begin
                    pipe[0] <= rd_word;
                    for (int i = 1; i < RD_LAT; i++)
                        pipe[i] <= pipe[i-1];
                end
            end
            assign dout = pipe[RD_LAT-1];
        end
    endgenerate

    assign sram_dq[7:0]  = (r && !bus.sram_lb_n) ? dout[7:0]  : 8'hzz;
    assign sram_dq[15:8] = (r && !bus.sram_ub_n) ? dout[15:8] : 8'hzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            pend_addr <= '0;
            pend_oor  <= 1'b0;
            pend_data <= 16'h0000;
            pend_be   <= 2'b00;
            prev_r    <= 1'b0;
            prev_addr <= 20'h0;
            wr_cnt    <= 8'h00;
            rd_cnt    <= 8'h00;
            err_cnt   <= 8'h00;
        end else begin
            prev_r    <= r;
            prev_addr <= bus.sram_addr;
            if (w) begin
                pend_addr <= a;
                pend_oor  <= oor;
                pend_data <= sram_dq;
                pend_be   <= ~{bus.sram_ub_n, bus.sram_lb_n};
            end
            unique case (st)
                IDLE:    st <= w ? WRITE : (r ? READ : IDLE);
                WRITE:   st <= w ? WRITE : IDLE;
                READ:    st <= w ? WRITE : (r ? READ : IDLE);
                default: st <= IDLE;
            endcase
            if (commit_wr)
                wr_cnt <= wr_cnt + 8'd1;
            if (rd_start && !oor)
                rd_cnt <= rd_cnt + 8'd1;
            err_cnt <= err_next;
        end
    end

    assign state = st;
endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the asynchronous 16-bit SRAM pin interface driven by our SRAM-master blocks (CE_N/OE_N/WE_N/UB_N/LB_N, 20-bit address, 16-bit bidirectional DQ). It stands in for the external SRAM chip so that master FSMs can be exercised on-chip and in simulation. It holds a small register-file memory, decodes the strobe pins into read and write accesses, commits writes at the end of the strobe, and exposes access counters for HEX or debug display.

## Interface
- ADDR_W, 4: implemented address bits. Depth is 2**ADDR_W words.
- RD_LAT, 0: read data latency in clk cycles, legal range 0..3.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- sram_addr  in  20  word address
- sram_dq  inout  16  data bus; driven only during reads
- sram_ce_n  in  1  chip enable, active-low
- sram_oe_n  in  1  output enable, active-low
- sram_we_n  in  1  write enable, active-low
- sram_ub_n  in  1  upper byte lane [15:8] enable, active-low
- sram_lb_n  in  1  lower byte lane [7:0] enable, active-low
- wr_cnt  out  8  committed writes; wraps 255 to 0
- rd_cnt  out  8  read accesses; wraps
- err_cnt  out  8  out-of-range accesses; saturates at 255
- state  out  2  FSM state, for debug

## Operation
- Conditions, evaluated on the raw pins:
  - W = !ce_n & !we_n.
  - R = !ce_n & !oe_n & we_n.
  - W dominates R, so OE is ignored whenever WE is low.
- Out of range: any of sram_addr[19:ADDR_W] nonzero.
- FSM states are IDLE=0, WRITE=1, READ=2.
  - IDLE: goes to WRITE if W, else to READ if R, else stays.
  - WRITE: on every edge with W, capture pend_addr, pend_data=sram_dq and lane enables. On the first edge with !W, commit and go to IDLE. The last captured sample wins.
  - READ: on an edge with W, go to WRITE (capture as above). On an edge with !R, go to IDLE.
- Commit rules:
  - mem[pend_addr] updates only the enabled lanes.
  - If both lanes are disabled, the write is not counted and memory is unchanged.
  - If out of range, memory is unchanged, err_cnt increments and wr_cnt does not.
  - Otherwise wr_cnt increments.
- Read path:
  - sram_dq is driven combinationally whenever R holds.
  - Disabled lanes are tri-stated per byte.
  - Out-of-range addresses read 16'h0000.
  - If a write is pending or committing to the same address, the pending data is forwarded.
- rd_cnt increments on each edge where R holds and either the previous edge had !R or sram_addr differs from the previously sampled address. An out-of-range read start increments err_cnt instead.
- Reset clears the FSM to IDLE, all counters, and pend state. A pending write is discarded, never committed.
- Memory reset behaviour is set by the macro described under Configuration.

## Timing
- Write:
  - Pins go active after edge E1.
  - E2 captures the access.
  - The master deasserts after E2.
  - E3 commits; memory and wr_cnt are visible after E3.
  - Minimum strobe width is one cycle.
- Read with RD_LAT=0: data is a combinational function of the pins, valid in the same cycle.
- Read with RD_LAT=L≥1:
  - The address is sampled at edge k.
  - Data appears after edge k+L-1 through an L-stage pipeline.
  - Pipeline stages advance every cycle.
  - The drive enable stays combinational on R.
- Write then read of the same address in back-to-back cycles: the read returns the new data through forwarding, for any RD_LAT.
- Simultaneous W and R: treated as a write, and DQ is not driven.
- Counter wrap: wr_cnt and rd_cnt go 255 to 0. err_cnt holds at 255.

## Configuration
- SRAM_RESP_INIT_EN defined:
  - rst_n also loads mem[i] = {8'h00, 8'(DEPTH-1-i)}, a descending pattern for sort-master tests.
  - Every reset reloads this pattern.
- Not defined:
  - Memory has no reset and keeps its contents across rst_n; it is X at simulation start.
  - No reset logic is inferred on the memory array.

## Test plan
- With SRAM_RESP_INIT_EN, ADDR_W=4, RD_LAT=0: reset, then read addresses 0..3 with CE/OE held low and the address stepping each cycle. DQ = 000F, 000E, 000D, 000C and rd_cnt = 4.
- Write 16'h1234 to addr 2 with LB only (CE/WE low for one cycle), then read addr 2. Result is 16'h??34, with the upper byte unchanged. wr_cnt=1 and commit is visible one edge after the strobe ends.
- Write to addr 20'h00010 (out of range), then read it. Memory is unchanged, the read returns 0000, and err_cnt=2.
- RD_LAT=2, read addr 1 immediately after writing 16'hBEEF to addr 1. DQ = BEEF after the second edge, via forwarding.
- Assert rst_n low while in WRITE with data pending. No commit happens, state=0 and counters are 0.
- Issue 256 one-cycle writes. wr_cnt wraps to 0. Drive CE, OE and WE low together: DQ stays Z and a write is committed.
